// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS instruction/data bus arbiter.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2,
      ACK  = 2'd3
   } state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_e;

   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/bus_wait_watchdog.sv
// Counts consecutive stalled bus cycles and strobes when the wait limit is reached.
module bus_wait_watchdog #(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic active_i,
   input  logic waitrequest_i,
   output logic timeout_c_o
);

   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (active_i && waitrequest_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // This stalled cycle is the one that brings the count up to the limit.
   assign timeout_c_o = active_i && waitrequest_i && (cnt_q == LIMIT_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates the single Avalon master port between instruction fetch and load/store,
// returning registered read data with a one-cycle acknowledge.
module mips_bus_arbiter #(
   parameter int unsigned ARB_MODE   = 1,
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_address,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        bus_timeout
);

   import mips_bus_pkg::*;

   localparam bit RR = (ARB_MODE != 0);

   state_e      state_q, state_d;
   gnt_e        last_q, last_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        iack_q, iack_d;
   logic        dack_q, dack_d;
   logic [31:0] irdata_q, irdata_d;
   logic [31:0] drdata_q, drdata_d;
   logic        busy_q, busy_d;
   logic        tmo_q, tmo_d;

   logic        d_pend;
   logic        wd_clr;
   logic        wd_active;
   logic        timeout_c;

   assign d_pend    = d_read | d_write;
   assign wd_active = (state_q == IGNT) || (state_q == DGNT);

   bus_wait_watchdog #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_W      (CNT_W)
   ) u_watchdog (
      .clk           (clk),
      .rst_n         (reset),
      .clr_i         (wd_clr),
      .active_i      (wd_active),
      .waitrequest_i (waitrequest),
      .timeout_c_o   (timeout_c)
   );

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      iack_d   = 1'b0;
      dack_d   = 1'b0;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      tmo_d    = tmo_q;
      wd_clr   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_req || d_pend) begin
               wd_clr = 1'b1;
               // Data wins unless round-robin says fetch is owed the bus.
               if (d_pend && (!i_req || !RR || (last_q == GNT_I))) begin
                  state_d = DGNT;
                  last_d  = GNT_D;
                  addr_d  = d_address;
                  be_d    = d_byteenable;
                  wdata_d = d_writedata;
                  wr_d    = d_write;
                  rd_d    = ~d_write;
               end else begin
                  state_d = IGNT;
                  last_d  = GNT_I;
                  addr_d  = i_address;
                  be_d    = BE_WORD;
                  wdata_d = '0;
                  wr_d    = 1'b0;
                  rd_d    = 1'b1;
               end
            end
         end
         IGNT, DGNT: begin
            if (!waitrequest || timeout_c) begin
               state_d = ACK;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               if (waitrequest) begin
                  tmo_d = 1'b1;
               end
               if (state_q == IGNT) begin
                  iack_d   = 1'b1;
                  irdata_d = waitrequest ? 32'd0 : readdata;
               end else begin
                  dack_d = 1'b1;
                  if (waitrequest) begin
                     drdata_d = 32'd0;
                  end else if (!wr_q) begin
                     drdata_d = readdata;
                  end
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         last_q   <= GNT_D;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         iack_q   <= 1'b0;
         dack_q   <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
         busy_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         iack_q   <= iack_d;
         dack_q   <= dack_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         busy_q   <= busy_d;
         tmo_q    <= tmo_d;
      end
   end

   assign address     = addr_q;
   assign writedata   = wdata_q;
   assign byteenable  = be_q;
   assign read        = rd_q;
   assign write       = wr_q;
   assign i_ack       = iack_q;
   assign d_ack       = dack_q;
   assign i_rdata     = irdata_q;
   assign d_rdata     = drdata_q;
   assign busy        = busy_q;
   assign bus_timeout = tmo_q;

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon memory-mapped master port between two requesters inside the multicycle MIPS CPU: the instruction-fetch port and the load/store data port.
- Each bus transaction is sequenced through an explicit grant state machine that honours `waitrequest`.
- Read data is captured and returned with a one-cycle acknowledge.
- A wait-cycle watchdog flags a hung slave.

Parameters:
- ARB_MODE, 1, 0 = data port always wins a tie; 1 = round-robin tie-break on the last grant.
- WAIT_LIMIT, 255, number of consecutive `waitrequest`-high cycles tolerated before a transaction is aborted (range 1..65535).
- CNT_W, 16, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch request (read only)
- i_address  in  32  fetch address
- i_ack  out  1  one-cycle pulse: fetch done, i_rdata valid
- i_rdata  out  32  fetched word, held until the next i_ack
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  32  data address
- d_writedata  in  32  store data
- d_byteenable  in  4  store/load byte lanes
- d_ack  out  1  one-cycle pulse: data transfer done
- d_rdata  out  32  load word, held until the next d_ack
- address  out  32  Avalon address
- read  out  1  Avalon read
- write  out  1  Avalon write
- waitrequest  in  1  Avalon stall
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon byte enables
- readdata  in  32  Avalon read data
- busy  out  1  high while the state is not IDLE
- bus_timeout  out  1  sticky flag: a watchdog abort has occurred

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: `address`, `read`, `write`, `writedata`, `byteenable`, acks, rdata regs, `busy`, `bus_timeout`.
  - The last-grant bit goes to data.
  - The wait counter goes to 0.
  - An in-flight transaction is dropped with no ack.
- States: IDLE, IGNT, DGNT, ACK.
- IDLE:
  - Sample `i_req` and `d_rd_or_wr` (`d_read | d_write`).
  - One pending: grant it.
  - Both pending: ARB_MODE=0 → DGNT; ARB_MODE=1 → grant opposite of the last grant.
  - On grant, register `address`, `byteenable` (4'b1111 for fetch), `writedata`, and `read`/`write` onto the bus.
  - Update the last-grant bit.
  - Clear the wait counter.
- `d_read` and `d_write` both high: treated as a write.
- IGNT / DGNT:
  - Bus signals are held stable while `waitrequest`=1.
  - On the first cycle with `waitrequest`=0:
    - Capture `readdata` into the granted rdata reg (reads only; writes leave d_rdata unchanged).
    - Deassert `read`/`write`.
    - Pulse the granted ack for exactly one cycle.
    - Go to ACK.
- ACK: one dead cycle so requesters can drop or replace their request; then IDLE. `busy` remains 1 in ACK.
- Latency:
  - Request seen in IDLE at cycle N → bus strobe visible N+1.
  - If `waitrequest`=0 at N+1 → ack at N+2, IDLE at N+3.
  - Minimum 3 cycles per transaction; back-to-back grants are possible every 3 cycles.
- Requester rules:
  - The request must be held until its ack.
  - Request inputs are ignored outside IDLE; changing them mid-transaction has no effect.
  - A request deasserted before grant is never issued.
- Watchdog:
  - The wait counter increments each IGNT/DGNT cycle with `waitrequest`=1, saturating at WAIT_LIMIT.
  - On reaching WAIT_LIMIT: deassert `read`/`write`, pulse the granted ack with rdata forced to 0, set `bus_timeout`, go to ACK.
  - `bus_timeout` clears only on reset.
- Fairness: with ARB_MODE=1 and both requesters continuously requesting, grants strictly alternate.
- Acks: never more than one ack high in a cycle; the two acks are never high together.
- CPU halt (no requests): stays in IDLE, bus idle, `busy`=0.

Decomposition:
- Package mips_bus_pkg holds:
  - state enum (IDLE, IGNT, DGNT, ACK)
  - grant-source enum (GNT_I, GNT_D)
  - constant BE_WORD = 4'b1111
- One natural sub-module: bus_wait_watchdog (counter, saturation, timeout strobe). The arbiter FSM and datapath registers stay in the top module.

Test Plan:
- Fetch, zero wait: `i_req`=1, `i_address`=32'hBFC00000, `waitrequest`=0, `readdata`=32'h24020005 → `read`=1 at N+1 with `address` BFC00000, `byteenable` F; `i_ack` pulse at N+2; `i_rdata`=24020005.
- Store with waits: `d_write`=1, `d_address`=0x1004, `d_writedata`=0xDEADBEEF, `d_byteenable`=4'b0011, `waitrequest` high 3 cycles → `write`/`address`/`writedata`/`byteenable` stable 4 cycles; `d_ack` on the cycle after `waitrequest` falls; no `i_ack`.
- Simultaneous requests, ARB_MODE=0 → data granted first, fetch second. Same with ARB_MODE=1 after a fetch-last grant → data first; after a data-last grant → fetch first. Under continuous requests, grants alternate I,D,I,D.
- Watchdog, WAIT_LIMIT=4, `waitrequest` stuck 1 on a `d_read` → strobe removed after 4 stalled cycles; `d_ack` pulse with `d_rdata`=0; `bus_timeout`=1, and it stays 1 through later good transactions.
- Reset mid-transaction: assert reset low during DGNT with `waitrequest`=1 → `read`, `write`, `busy` drop to 0 asynchronously; no ack. After release, a new `i_req` is served normally.
- `d_read` and `d_write` both high → write issued, `read` stays 0.
